// File: rtl/mag_cmd_pkg.sv
// mag_cmd_pkg: shared state encoding, op constants and helpers for the magnet command driver
package mag_cmd_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
  localparam logic OP_GRAB = 1'b1;
  localparam logic OP_RELEASE = 1'b0;
  function automatic int max_int(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mag_cmd_ctrl_if.sv
// mag_cmd_ctrl_if: command handshake plus latch drive/feedback for mag_cmd_ctrl
interface mag_cmd_ctrl_if;
  logic req_valid, req_op, req_ready, estop, mag_on;
  logic set, reset, busy, done, err;
  modport master(output req_valid, req_op, estop, mag_on,
                 input req_ready, set, reset, busy, done, err);
  modport slave(input req_valid, req_op, estop, mag_on,
                output req_ready, set, reset, busy, done, err);
endinterface

// File: rtl/mag_cmd_timer.sv
// mag_cmd_timer: loadable down-counter that stops at zero
module mag_cmd_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mag_cmd_ctrl.sv
// mag_cmd_ctrl: timed, mutually exclusive set/reset pulses to the magnet latch with settle check
module mag_cmd_ctrl import mag_cmd_pkg::*; #(
  parameter int PULSE_LEN  = 4,
  parameter int SETTLE_LEN = 8
) (
  input logic           clk,
  input logic           rst_n,
  mag_cmd_ctrl_if.slave bus
);
  localparam int CW = $clog2(max_int(PULSE_LEN, SETTLE_LEN) + 1);
  state_t state;
  logic op_q, set_q, reset_q, done_q, err_q, busy_q;
  logic load, zero, accept, pulse_end;
  logic [CW-1:0] load_val;
  always_comb begin
    accept = (state == IDLE) & bus.req_valid & ~bus.estop;
    pulse_end = (state == PULSE) & zero;
    load = bus.estop | (accept & (bus.req_op != bus.mag_on)) | pulse_end;
    load_val = (pulse_end & ~bus.estop) ? CW'(SETTLE_LEN - 1) : CW'(PULSE_LEN - 1);
  end
  mag_cmd_timer #(.W(CW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= OP_RELEASE;
      set_q <= 1'b0;
      reset_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // estop preempts everything, including a grab pulse already in flight
      if (bus.estop) begin
        state <= PULSE;
        op_q <= OP_RELEASE;
        set_q <= 1'b0;
        reset_q <= 1'b1;
        busy_q <= 1'b1;
      end else begin
        case (state)
          IDLE: if (accept) begin
            op_q <= bus.req_op;
            err_q <= 1'b0;
            busy_q <= 1'b1;
            if (bus.req_op != bus.mag_on) begin
              state <= PULSE;
              set_q <= bus.req_op;
              reset_q <= ~bus.req_op;
            end else begin
              state <= CHECK;
              done_q <= 1'b1;
            end
          end
          PULSE: if (zero) begin
            state <= SETTLE;
            set_q <= 1'b0;
            reset_q <= 1'b0;
          end
          SETTLE: if (zero) begin
            state <= CHECK;
            done_q <= 1'b1;
            err_q <= bus.mag_on != op_q;
          end
          CHECK: begin
            state <= IDLE;
            busy_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge clk)
    if (rst_n) assert (!(set_q && reset_q));
  assign bus.req_ready = (state == IDLE) & ~bus.estop;
  assign bus.set = set_q;
  assign bus.reset = reset_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_mag_cmd_ctrl.sv
// tb_mag_cmd_ctrl: directed and random stimulus against a time-since-command reference model
module tb_mag_cmd_ctrl;
  localparam int P = 4;
  localparam int S = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mag_cmd_ctrl_if bus();
  mag_cmd_ctrl #(.PULSE_LEN(P), .SETTLE_LEN(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = -1;
  bit mop, mnoop, merr, exp_done;
  bit latch_en = 1'b1;
  logic [2:0] ops = 3'b101;
  function automatic int span();
    return mnoop ? 1 : P + S + 1;
  endfunction
  function automatic bit idle();
    return t0 < 0 || cyc - t0 < 1 || cyc - t0 > span();
  endfunction
  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask
  task automatic step();
    int d;
    bit act;
    if (!rst_n) begin
      t0 = -1;
      merr = 1'b0;
    end else if (bus.estop) begin
      t0 = cyc;
      mop = 1'b0;
      mnoop = 1'b0;
    end else if (idle() && bus.req_valid) begin
      t0 = cyc;
      mop = bus.req_op;
      mnoop = bus.req_op == bus.mag_on;
      merr = 1'b0;
    end
    if (rst_n && t0 >= 0 && cyc + 1 - t0 == span()) merr = bus.mag_on != mop;
    @(posedge clk);
    #1;
    cyc++;
    d = cyc - t0;
    act = t0 >= 0 && d >= 1 && d <= span();
    exp_done = act && d == span();
    chk("set", bus.set, act && !mnoop && mop && d <= P);
    chk("reset", bus.reset, act && !mnoop && !mop && d <= P);
    chk("busy", bus.busy, act);
    chk("done", bus.done, exp_done);
    chk("err", bus.err, merr);
    chk("ready", bus.req_ready, !act && !bus.estop);
    chk("exclusive", bus.set & bus.reset, 1'b0);
    if (latch_en) begin
      if (bus.set) bus.mag_on = 1'b1;
      else if (bus.reset) bus.mag_on = 1'b0;
    end
  endtask
  initial begin
    bus.req_valid = 1'b1;
    bus.req_op = 1'b1;
    bus.estop = 1'b0;
    bus.mag_on = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    step();
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (14) step();
    bus.req_op = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (14) step();
    latch_en = 1'b0;
    bus.req_op = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (17) step();
    bus.req_op = 1'b0;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (3) step();
    latch_en = 1'b1;
    bus.req_op = 1'b1;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.estop = 1'b1;
    step();
    bus.estop = 1'b0;
    repeat (14) step();
    bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_op = ops[i];
      for (int n = 0; n < 30; n++) begin
        step();
        if (exp_done) break;
      end
    end
    bus.req_valid = 1'b0;
    step();
    repeat (1500) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_op = 1'($urandom_range(0, 1));
      bus.estop = $urandom_range(0, 29) == 0;
      rst_n = $urandom_range(0, 149) != 0;
      if ($urandom_range(0, 15) == 0) latch_en = $urandom_range(0, 3) != 0;
      if (!latch_en && $urandom_range(0, 9) == 0) bus.mag_on = ~bus.mag_on;
      step();
    end
    rst_n = 1'b1;
    bus.estop = 1'b0;
    bus.req_valid = 1'b0;
    repeat (20) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
